// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between NUM_REQ byte-stream requesters,
// holding each grant for a whole frame. Define UART_ARB_PRIO_EN to make requester 0 strict priority.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_BITS = 8,
    parameter int MAX_BURST = 16,
    localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ*DATA_BITS-1:0] req_data,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    output logic [DATA_BITS-1:0]         uart_data,
    output logic                         uart_valid,
    input  logic                         uart_ready,
    output logic [GW-1:0]                grant_id,
    output logic                         busy
);

    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [GW-1:0] LAST_ID  = GW'(NUM_REQ - 1);
    localparam logic [BW-1:0] CAP_LAST = BW'((MAX_BURST > 0) ? MAX_BURST - 1 : 0);

    typedef enum logic {
        ARB,
        GRANT
    } state_t;

    state_t               state_q, state_d;
    logic [GW-1:0]        grant_q, grant_d;
    logic [GW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [BW-1:0]        beat_cnt_q, beat_cnt_d;
    logic [GW-1:0]        pick;
    logic                 sel_valid, sel_last, transfer, release_grant;
    logic [DATA_BITS-1:0] sel_data;

    // First set bit at or above ptr, wrapping modulo NUM_REQ.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] v,
                                              input logic [GW-1:0]      ptr);
        int   idx;
        logic hit;
        rr_pick = '0;
        hit     = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!hit && v[idx[GW-1:0]]) begin
                rr_pick = idx[GW-1:0];
                hit     = 1'b1;
            end
        end
    endfunction

    always_comb begin
        pick = rr_pick(req_valid, rr_ptr_q);
`ifdef UART_ARB_PRIO_EN
        if (req_valid[0]) pick = '0;
`endif
    end

    // NOTE: every signal driven in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel_data  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q == GW'(i)) begin
                sel_data  = req_data[i*DATA_BITS +: DATA_BITS];
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        uart_valid    = 1'b0;
        uart_data     = '0;
        req_ready     = '0;
        transfer      = 1'b0;
        release_grant = 1'b0;
        case (state_q)
            ARB: begin
                if (|req_valid) begin
                    grant_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = GRANT;
                end
            end
            GRANT: begin
                uart_valid = sel_valid;
                uart_data  = sel_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = uart_ready && (grant_q == GW'(i));
                end
                transfer = sel_valid && uart_ready;
                if (transfer) begin
                    beat_cnt_d    = beat_cnt_q + 1'b1;
                    release_grant = sel_last || ((MAX_BURST != 0) && (beat_cnt_q == CAP_LAST));
                    if (release_grant) begin
                        state_d = ARB;
                        // Freed requester becomes lowest priority in the next arbitration.
`ifdef UART_ARB_PRIO_EN
                        if (grant_q != '0)
`endif
                            rr_ptr_d = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign grant_id = grant_q;
    assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized traffic checked
// against a frame-level reference model (MAX_BURST=16 and MAX_BURST=4 instances).
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int DB = 8;
    localparam int GW = 2;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*DB-1:0] req_data;
    logic [N-1:0]    req_valid, req_last;
    logic            uart_ready;

    logic [N-1:0]    ready_a, ready_b;
    logic [DB-1:0]   data_a, data_b;
    logic            valid_a, valid_b, busy_a, busy_b;
    logic [GW-1:0]   gid_a, gid_b;

    logic            sel;
    logic [N-1:0]    obs_ready;
    logic [DB-1:0]   obs_data;
    logic            obs_valid, obs_busy;
    logic [GW-1:0]   obs_gid;

    int checks = 0;
    int errors = 0;

    // Requester byte streams and the valid gate used to model stalls/toggling.
    logic [7:0] mem [N][256];
    logic       lst [N][256];
    int         wp [N];
    int         rp [N];
    logic [N-1:0] mask;

    // Reference model: owner is -1 while arbitrating.
    int m_owner, m_gid, m_ptr, m_beats, cap;
    logic [GW-1:0] exp_gid;
    logic          exp_busy, exp_valid;
    logic [DB-1:0] exp_data;
    logic [N-1:0]  exp_ready;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .MAX_BURST(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(ready_a), .uart_data(data_a), .uart_valid(valid_a),
        .uart_ready(uart_ready), .grant_id(gid_a), .busy(busy_a)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .DATA_BITS(DB), .MAX_BURST(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .req_data(req_data), .req_valid(req_valid),
        .req_last(req_last), .req_ready(ready_b), .uart_data(data_b), .uart_valid(valid_b),
        .uart_ready(uart_ready), .grant_id(gid_b), .busy(busy_b)
    );

    assign obs_ready = sel ? ready_b : ready_a;
    assign obs_data  = sel ? data_b  : data_a;
    assign obs_valid = sel ? valid_b : valid_a;
    assign obs_busy  = sel ? busy_b  : busy_a;
    assign obs_gid   = sel ? gid_b   : gid_a;

    function automatic int m_pick(input logic [N-1:0] v);
`ifdef UART_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_owner = -1;
        m_gid   = 0;
        m_ptr   = 0;
        m_beats = 0;
    endtask

    task automatic push(input int r, input logic [7:0] d, input logic l);
        mem[r][wp[r]] = d;
        lst[r][wp[r]] = l;
        wp[r]++;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (rp[i] < wp[i]) begin
                req_data[i*DB +: DB] = mem[i][rp[i]];
                req_last[i]          = lst[i][rp[i]];
                req_valid[i]         = mask[i];
            end else begin
                req_data[i*DB +: DB] = '0;
                req_last[i]          = 1'b0;
                req_valid[i]         = 1'b0;
            end
        end
        #1;
        exp_busy  = (m_owner >= 0);
        exp_gid   = GW'(m_gid);
        exp_valid = (m_owner >= 0) && req_valid[m_owner];
        exp_data  = (m_owner >= 0) ? req_data[m_owner*DB +: DB] : '0;
        exp_ready = (m_owner >= 0 && uart_ready) ? (N'(1) << m_owner) : '0;
    endtask

    task automatic advance();
        int   o;
        logic l;
        @(posedge clk);
        if (!rst_n) begin
            m_reset();
        end else if (m_owner < 0) begin
            o = m_pick(req_valid);
            if (o >= 0) begin
                m_owner = o;
                m_gid   = o;
                m_beats = 0;
            end
        end else if (req_valid[m_owner] && uart_ready) begin
            l = lst[m_owner][rp[m_owner]];
            rp[m_owner]++;
            if (l || (cap != 0 && m_beats == cap - 1)) begin
`ifdef UART_ARB_PRIO_EN
                if (m_owner != 0)
`endif
                    m_ptr = (m_owner + 1) % N;
                m_owner = -1;
            end else begin
                m_beats++;
            end
        end
        @(negedge clk);
        drive();
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        uart_ready = 1'b0;
        mask       = '1;
        cap        = sel ? 4 : 16;
        for (int i = 0; i < N; i++) begin
            wp[i] = 0;
            rp[i] = 0;
        end
        m_reset();
        drive();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive();
    endtask

    task automatic wait_grant(output int id);
        id = -1;
        for (int n = 0; n < 20; n++) begin
            if (obs_busy) begin
                id = int'(obs_gid);
                return;
            end
            advance();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        sel   = 1'b0;
        apply_reset();
        rst_n = 1'b0;
        push(1, 8'h5a, 1'b1);
        uart_ready = 1'b1;
        drive();
        checks++;
        if ({obs_gid, obs_busy, obs_valid, obs_data, obs_ready} !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0000", {obs_gid, obs_busy, obs_valid, obs_data, obs_ready});
        end
        advance();
        checks++;
        if ({obs_gid, obs_busy, obs_valid, obs_data, obs_ready} !== 16'h0) begin
            errors++;
            $display("FAIL reset_held got %h want 0000", {obs_gid, obs_busy, obs_valid, obs_data, obs_ready});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_frame();
        apply_reset();
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b0);
        push(1, 8'h43, 1'b1);
        uart_ready = 1'b1;
        drive();
        checks++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0 || obs_ready !== 4'b0) begin
            errors++;
            $display("FAIL single_arb busy=%b valid=%b ready=%b want 0 0 0000", obs_busy, obs_valid, obs_ready);
        end
        for (int k = 0; k < 3; k++) begin
            advance();
            checks++;
            if (obs_gid !== 2'd1 || obs_valid !== 1'b1 || obs_data !== 8'(8'h41 + k) || obs_ready !== 4'b0010) begin
                errors++;
                $display("FAIL single_beat%0d gid=%0d valid=%b data=%h ready=%b want 1 1 %h 0010",
                         k, obs_gid, obs_valid, obs_data, obs_ready, 8'(8'h41 + k));
            end
        end
        advance();
        checks++;
        if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release busy=%b valid=%b want 0 0", obs_busy, obs_valid);
        end
    endtask

    task automatic test_fairness();
        int id;
`ifdef UART_ARB_PRIO_EN
        int order [6] = '{0, 0, 0, 1, 2, 3};
`else
        int order [6] = '{0, 1, 2, 3, 0, 1};
`endif
        apply_reset();
        for (int r = 0; r < N; r++)
            for (int k = 0; k < 3; k++) push(r, 8'(16 * r + k), 1'b1);
        uart_ready = 1'b1;
        drive();
        for (int g = 0; g < 6; g++) begin
            wait_grant(id);
            checks++;
            if (id !== order[g]) begin
                errors++;
                $display("FAIL fair_order%0d got %0d want %0d", g, id, order[g]);
            end
            checks++;
            if (obs_ready !== (4'b0001 << order[g])) begin
                errors++;
                $display("FAIL fair_ready%0d got %b want %b", g, obs_ready, 4'b0001 << order[g]);
            end
            advance();
        end
    endtask

    task automatic test_burst_cap();
        int id;
        sel = 1'b1;
        apply_reset();
        for (int k = 0; k < 10; k++) push(2, 8'(k), 1'b0);
        push(3, 8'ha0, 1'b0);
        push(3, 8'ha1, 1'b0);
        push(3, 8'ha2, 1'b1);
        uart_ready = 1'b1;
        drive();
        wait_grant(id);
        checks++;
        if (id !== 2) begin
            errors++;
            $display("FAIL cap_first got %0d want 2", id);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_gid !== 2'd2 || obs_valid !== 1'b1 || obs_data !== 8'(k)) begin
                errors++;
                $display("FAIL cap_beat%0d gid=%0d valid=%b data=%h want 2 1 %h", k, obs_gid, obs_valid, obs_data, 8'(k));
            end
            advance();
        end
        checks++;
        if (obs_busy !== 1'b0) begin
            errors++;
            $display("FAIL cap_release busy=%b want 0", obs_busy);
        end
        advance();
        checks++;
        if (obs_gid !== 2'd3 || obs_busy !== 1'b1 || obs_data !== 8'ha0) begin
            errors++;
            $display("FAIL cap_next gid=%0d busy=%b data=%h want 3 1 a0", obs_gid, obs_busy, obs_data);
        end
        sel = 1'b0;
    endtask

    task automatic test_stall_valid();
        int id;
        apply_reset();
        for (int k = 0; k < 5; k++) push(0, 8'(8'h50 + k), k == 4);
        push(1, 8'h60, 1'b0);
        push(1, 8'h61, 1'b1);
        uart_ready = 1'b1;
        drive();
        wait_grant(id);
        checks++;
        if (id !== 0 || obs_data !== 8'h50) begin
            errors++;
            $display("FAIL stall_first gid=%0d data=%h want 0 50", id, obs_data);
        end
        advance();
        advance();
        mask[0] = 1'b0;
        drive();
        for (int c = 0; c < 20; c++) begin
            checks++;
            if ({obs_gid, obs_busy, obs_valid, obs_ready[1]} !== 5'b00100) begin
                errors++;
                $display("FAIL stall_hold%0d gid=%0d busy=%b valid=%b ready1=%b want 0 1 0 0",
                         c, obs_gid, obs_busy, obs_valid, obs_ready[1]);
            end
            advance();
        end
        mask[0] = 1'b1;
        drive();
        checks++;
        if (obs_gid !== 2'd0 || obs_valid !== 1'b1 || obs_data !== 8'h52) begin
            errors++;
            $display("FAIL stall_resume gid=%0d valid=%b data=%h want 0 1 52", obs_gid, obs_valid, obs_data);
        end
        repeat (3) advance();
        wait_grant(id);
        checks++;
        if (id !== 1 || obs_data !== 8'h60) begin
            errors++;
            $display("FAIL stall_next gid=%0d data=%h want 1 60", id, obs_data);
        end
    endtask

    task automatic test_stall_ready();
        int id;
        apply_reset();
        push(3, 8'h77, 1'b0);
        push(3, 8'h78, 1'b1);
        uart_ready = 1'b0;
        drive();
        wait_grant(id);
        checks++;
        if (id !== 3) begin
            errors++;
            $display("FAIL rdy_grant got %0d want 3", id);
        end
        for (int c = 0; c < 100; c++) begin
            checks++;
            if (obs_valid !== 1'b1 || obs_data !== 8'h77 || obs_ready !== 4'b0) begin
                errors++;
                $display("FAIL rdy_hold%0d valid=%b data=%h ready=%b want 1 77 0000", c, obs_valid, obs_data, obs_ready);
            end
            advance();
        end
        uart_ready = 1'b1;
        drive();
        checks++;
        if (obs_ready !== 4'b1000 || obs_data !== 8'h77) begin
            errors++;
            $display("FAIL rdy_accept ready=%b data=%h want 1000 77", obs_ready, obs_data);
        end
        advance();
        checks++;
        if (obs_valid !== 1'b1 || obs_data !== 8'h78) begin
            errors++;
            $display("FAIL rdy_second valid=%b data=%h want 1 78", obs_valid, obs_data);
        end
    endtask

    task automatic test_reset_mid_frame();
        int id;
        apply_reset();
        for (int k = 0; k < 5; k++) push(2, 8'(8'h20 + k), k == 4);
        uart_ready = 1'b1;
        drive();
        wait_grant(id);
        advance();
        advance();
        push(1, 8'h11, 1'b1);
        push(3, 8'h33, 1'b1);
        drive();
        checks++;
        if (obs_gid !== 2'd2 || obs_data !== 8'h22) begin
            errors++;
            $display("FAIL mid_pre gid=%0d data=%h want 2 22", obs_gid, obs_data);
        end
        #2;
        rst_n = 1'b0;
        m_reset();
        #1;
        checks++;
        if ({obs_gid, obs_busy, obs_valid, obs_data, obs_ready} !== 16'h0) begin
            errors++;
            $display("FAIL mid_async got %h want 0000", {obs_gid, obs_busy, obs_valid, obs_data, obs_ready});
        end
        advance();
        rst_n = 1'b1;
        drive();
        wait_grant(id);
        checks++;
        if (id !== 1 || obs_data !== 8'h11) begin
            errors++;
            $display("FAIL mid_regrant gid=%0d data=%h want 1 11", id, obs_data);
        end
    endtask

    task automatic test_priority();
        int a, b;
`ifdef UART_ARB_PRIO_EN
        int first = 0, second = 2;
`else
        int first = 2, second = 0;
`endif
        apply_reset();
        push(1, 8'h31, 1'b1);
        uart_ready = 1'b1;
        drive();
        wait_grant(a);
        advance();
        push(0, 8'h01, 1'b1);
        push(2, 8'h02, 1'b1);
        drive();
        wait_grant(a);
        checks++;
        if (a !== first) begin
            errors++;
            $display("FAIL prio_first got %0d want %0d", a, first);
        end
        advance();
        wait_grant(b);
        checks++;
        if (b !== second) begin
            errors++;
            $display("FAIL prio_second got %0d want %0d", b, second);
        end
    endtask

    task automatic test_random(input logic which);
        int len;
        sel = which;
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (wp[i] - rp[i] < 4 && wp[i] < 230 && $urandom_range(3) == 0) begin
                    len = $urandom_range(20, 1);
                    for (int k = 0; k < len; k++) push(i, 8'($urandom), k == len - 1);
                end
                mask[i] = ($urandom_range(7) != 0);
            end
            uart_ready = ($urandom_range(3) != 0);
            drive();
            checks++;
            if ({obs_gid, obs_busy, obs_valid, obs_data, obs_ready} !==
                {exp_gid, exp_busy, exp_valid, exp_data, exp_ready}) begin
                errors++;
                $display("FAIL rand%0d_c%0d gid/busy/valid/data/ready got %0d %b %b %h %b want %0d %b %b %h %b",
                         which, c, obs_gid, obs_busy, obs_valid, obs_data, obs_ready,
                         exp_gid, exp_busy, exp_valid, exp_data, exp_ready);
            end
            checks++;
            if ($countones(obs_ready) > 1) begin
                errors++;
                $display("FAIL rand%0d_onehot c%0d ready=%b want at most one bit", which, c, obs_ready);
            end
            advance();
        end
        sel = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before end of tests");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        sel        = 1'b0;
        mask       = '1;
        uart_ready = 1'b0;
        req_data   = '0;
        req_valid  = '0;
        req_last   = '0;
        test_reset();
        test_single_frame();
        test_fairness();
        test_burst_cap();
        test_stall_valid();
        test_stall_ready();
        test_reset_mid_frame();
        test_priority();
        test_random(1'b0);
        test_random(1'b1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
